// File: rtl/ikon_driver_if.sv
// ikon_driver_if -- command/response bundle between a burst master and ikon_driver.
//   load/data/len : shadow-register load (data holds NSYM 2-bit symbols)
//   start/abort   : burst control
//   z1/z0         : registered response bits from the downstream symbol FSM
//   x1/x0         : registered symbol outputs to the downstream FSM
//   busy/done     : burst status (done is a one-cycle pulse)
//   resp/hits     : captured responses and count of non-zero responses
interface ikon_driver_if #(parameter int NSYM = 8) ();
    logic                load;
    logic [2*NSYM-1:0]   data;
    logic [3:0]          len;
    logic                start;
    logic                abort;
    logic                z1;
    logic                z0;
    logic                x1;
    logic                x0;
    logic                busy;
    logic                done;
    logic [2*NSYM-1:0]   resp;
    logic [3:0]          hits;

    modport master (output load, data, len, start, abort, z1, z0,
                    input  x1, x0, busy, done, resp, hits);
    modport slave  (input  load, data, len, start, abort, z1, z0,
                    output x1, x0, busy, done, resp, hits);
endinterface

// File: rtl/ikon_driver.sv
// ikon_driver -- sends a burst of up to NSYM 2-bit symbols to a downstream
// symbol FSM and collects its registered 2-bit responses.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : ikon_driver_if.slave (load/data/len/start/abort/z in, x/busy/done/resp/hits out)
// Symbol i is driven on the i-th edge of the burst; its response comes back
// two edges later and is captured under a separate capture index, so captures
// overlap SEND and finish during the two DRAIN cycles.
module ikon_driver #(
    parameter int NSYM = 8
) (
    input logic          clk,
    input logic          rst,
    ikon_driver_if.slave bus
);
    localparam int         W      = 2 * NSYM;
    localparam logic [3:0] NSYM_L = 4'(NSYM);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] data_q, data_d;    // shadow data
    logic [3:0]   len_q, len_d;      // shadow length, already saturated
    logic [W-1:0] sh_q, sh_d;        // working copy shifted out one symbol per edge
    logic [3:0]   idx_q, idx_d;      // symbols driven so far
    logic [3:0]   cidx_q, cidx_d;    // responses captured so far
    logic [W-1:0] resp_q, resp_d;
    logic [3:0]   hits_q, hits_d;
    logic [1:0]   x_q, x_d;
    logic         drain_q, drain_d;  // second DRAIN cycle
    // vld_q[0]: a symbol was driven on the last edge; vld_q[1]: its response
    // is on z now and is captured on this edge.
    logic [1:0]   vld_q, vld_d;

    logic [3:0]   len_sat;
    logic [3:0]   len_sel;
    logic [W-1:0] data_sel;

    assign len_sat  = (bus.len > NSYM_L) ? NSYM_L : bus.len;
    // load together with start uses the freshly presented values
    assign len_sel  = bus.load ? len_sat  : len_q;
    assign data_sel = bus.load ? bus.data : data_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        len_d   = len_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        cidx_d  = cidx_q;
        resp_d  = resp_q;
        hits_d  = hits_q;
        x_d     = 2'b00;
        drain_d = drain_q;
        vld_d   = {vld_q[0], 1'b0};

        if (vld_q[1]) begin
            for (int i = 0; i < NSYM; i++)
                if (cidx_q == 4'(i)) resp_d[2*i +: 2] = {bus.z1, bus.z0};
            cidx_d = cidx_q + 4'd1;
            if ((bus.z1 | bus.z0) && hits_q != 4'hF) hits_d = hits_q + 4'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    data_d = bus.data;
                    len_d  = len_sat;
                end
                if (bus.start) begin
                    resp_d = '0;
                    hits_d = '0;
                    cidx_d = '0;
                    idx_d  = '0;
                    if (len_sel == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d  = S_SEND;
                        x_d      = data_sel[1:0];
                        sh_d     = data_sel >> 2;
                        idx_d    = 4'd1;
                        vld_d[0] = 1'b1;
                    end
                end
            end
            S_SEND: begin
                if (idx_q == len_q) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end else begin
                    x_d      = sh_q[1:0];
                    sh_d     = sh_q >> 2;
                    idx_d    = idx_q + 4'd1;
                    vld_d[0] = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q) state_d = S_DONE;
                else         drain_d = 1'b1;
            end
            default: state_d = S_IDLE;  // DONE lasts one cycle
        endcase

        // abort beats every SEND/DRAIN transition, including the capture on this edge
        if ((state_q == S_SEND || state_q == S_DRAIN) && bus.abort) begin
            state_d = S_IDLE;
            x_d     = 2'b00;
            vld_d   = 2'b00;
            resp_d  = resp_q;
            hits_d  = hits_q;
            cidx_d  = cidx_q;
            idx_d   = idx_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            len_q   <= '0;
            sh_q    <= '0;
            idx_q   <= '0;
            cidx_q  <= '0;
            resp_q  <= '0;
            hits_q  <= '0;
            x_q     <= 2'b00;
            drain_q <= 1'b0;
            vld_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            cidx_q  <= cidx_d;
            resp_q  <= resp_d;
            hits_q  <= hits_d;
            x_q     <= x_d;
            drain_q <= drain_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.x1   = x_q[1];
    assign bus.x0   = x_q[0];
    assign bus.busy = (state_q == S_SEND) || (state_q == S_DRAIN);
    assign bus.done = (state_q == S_DONE);
    assign bus.resp = resp_q;
    assign bus.hits = hits_q;
endmodule
